// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter/sequencer for the cache-backed memory bus
// Optional hit/miss statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter #(
    parameter int MISS_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       rwb0,
    input  logic       rwb1,
    input  logic [5:0] addr0,
    input  logic [5:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       hit0,
    output logic       hit1,
    output logic       mem_rwb,
    output logic [5:0] mem_addr,
    output logic [7:0] mem_data,
    input  logic       mem_hit,
    input  logic [7:0] mem_out,
    output logic       busy,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MISS_WAIT - 1);

    state_t     state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_rwb_q, mem_rwb_d;
    logic [5:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_data_q, mem_data_d;
    logic       done0_q, done0_d, done1_q, done1_d;
    logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic       hit0_q, hit0_d, hit1_q, hit1_d;
    logic       fin, fin_hit;
    logic [7:0] fin_data;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        mem_rwb_d  = mem_rwb_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        hit0_d     = hit0_q;
        hit1_d     = hit1_q;
        fin        = 1'b0;
        fin_hit    = 1'b0;
        fin_data   = mem_rwb_q ? 8'h00 : mem_out;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester not served last wins; otherwise the lone requester.
                    gnt_d      = (req0 && req1) ? ~last_q : req1;
                    last_d     = gnt_d;
                    mem_rwb_d  = gnt_d ? rwb1 : rwb0;
                    mem_addr_d = gnt_d ? addr1 : addr0;
                    mem_data_d = gnt_d ? wdata1 : wdata0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_hit) begin
                    fin     = 1'b1;
                    fin_hit = 1'b1;
                end else begin
                    cnt_d   = WAIT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    fin = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Response registers load on entry to RESP so done and data appear together.
        if (fin) begin
            state_d   = RESP;
            mem_rwb_d = 1'b0;
            if (gnt_q) begin
                done1_d  = 1'b1;
                rdata1_d = fin_data;
                hit1_d   = fin_hit;
            end else begin
                done0_d  = 1'b1;
                rdata0_d = fin_data;
                hit0_d   = fin_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= 4'd0;
            mem_rwb_q  <= 1'b0;
            mem_addr_q <= 6'd0;
            mem_data_q <= 8'd0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata0_q   <= 8'd0;
            rdata1_q   <= 8'd0;
            hit0_q     <= 1'b0;
            hit1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            mem_rwb_q  <= mem_rwb_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            hit0_q     <= hit0_d;
            hit1_q     <= hit1_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic        resp_hit;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        resp_hit   = gnt_q ? hit1_q : hit0_q;
        if (state_q == RESP) begin
            if (resp_hit && hit_cnt_q != 16'hFFFF) begin
                hit_cnt_d = hit_cnt_q + 16'd1;
            end
            if (!resp_hit && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= 16'd0;
            miss_cnt_q <= 16'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = 16'd0;
    assign miss_cnt = 16'd0;
`endif

    assign done0    = done0_q;
    assign done1    = done1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign hit0     = hit0_q;
    assign hit1     = hit1_q;
    assign mem_rwb  = mem_rwb_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int MW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, rwb0, rwb1;
    logic [5:0]  addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        done0, done1, hit0, hit1;
    logic [7:0]  rdata0, rdata1;
    logic        mem_rwb, mem_hit, busy;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_data, mem_out;
    logic [15:0] hit_cnt, miss_cnt;

    logic        use_map;
    logic        d_hit;
    logic [7:0]  d_out;
    logic        hitmap [64];
    logic [7:0]  datamap [64];

    int npass = 0;
    int ntotal = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MISS_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .rwb0(rwb0), .rwb1(rwb1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .hit0(hit0), .hit1(hit1),
        .mem_rwb(mem_rwb), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_hit(mem_hit), .mem_out(mem_out),
        .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Memory system stand-in: either a fixed per-address map or directed values.
    always_comb begin
        if (use_map) begin
            mem_hit = hitmap[mem_addr];
            mem_out = datamap[mem_addr];
        end else begin
            mem_hit = d_hit;
            mem_out = d_out;
        end
    end

    typedef struct {
        logic       port;
        logic       rwb;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic       mhit;
        logic [7:0] mout;
        logic [7:0] exp_rdata;
        logic       exp_hit;
        int         exp_lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_port(input logic p, input logic r, input logic w, input logic [5:0] a, input logic [7:0] d);
        if (p) begin
            req1 = r; rwb1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; rwb0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic run_one(input vec_t v, input string nm);
        int  lat;
        logic got, other;
        lat = 0; got = 1'b0; other = 1'b0;
        use_map = 1'b0;
        d_hit = v.mhit;
        d_out = v.mout;
        drive_port(v.port, 1'b1, v.rwb, v.addr, v.wdata);
        for (int k = 1; k <= 40 && !got; k++) begin
            tick();
            if (k == 1) begin
                chk({nm, " mem_addr"}, mem_addr, v.addr);
                chk({nm, " mem_rwb"}, mem_rwb, v.rwb);
                if (v.rwb) chk({nm, " mem_data"}, mem_data, v.wdata);
            end
            if ((v.port ? done0 : done1) === 1'b1) other = 1'b1;
            if ((v.port ? done1 : done0) === 1'b1) begin
                got = 1'b1;
                lat = k;
                chk({nm, " rdata"}, v.port ? rdata1 : rdata0, v.exp_rdata);
                chk({nm, " hit"}, v.port ? hit1 : hit0, v.exp_hit);
                chk({nm, " resp mem_rwb"}, mem_rwb, 1'b0);
            end
        end
        chk({nm, " latency"}, lat, v.exp_lat);
        chk({nm, " other done"}, other, 1'b0);
        drive_port(v.port, 1'b0, 1'b0, 6'd0, 8'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt [5];
        vec_t vf;
        logic       rq [2];
        logic       rw [2];
        logic [5:0] ad [2];
        logic [7:0] wd [2];
        logic       dropped [2];
        logic       mlast, win, pend_valid, pend_port, pend_hit;
        logic [7:0] pend_rdata;
        logic [1:0] expd;
        int         pend_cycle, next_free, mhits, mmiss;

        vt[0] = '{1'b0, 1'b0, 6'h05, 8'h00, 1'b0, 8'hA5, 8'hA5, 1'b0, 2 + MW};
        vt[1] = '{1'b0, 1'b0, 6'h05, 8'h00, 1'b1, 8'hA5, 8'hA5, 1'b1, 2};
        vt[2] = '{1'b1, 1'b1, 6'h3F, 8'h5C, 1'b1, 8'hEE, 8'h00, 1'b1, 2};
        vt[3] = '{1'b1, 1'b0, 6'h12, 8'h00, 1'b1, 8'h3C, 8'h3C, 1'b1, 2};
        vt[4] = '{1'b0, 1'b1, 6'h2A, 8'h99, 1'b0, 8'h77, 8'h00, 1'b0, 2 + MW};

        reset = 1'b1;
        req0 = 0; req1 = 0; rwb0 = 0; rwb1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        use_map = 1'b0; d_hit = 1'b0; d_out = 8'h00;
        for (int i = 0; i < 64; i++) begin
            hitmap[i]  = 1'($urandom_range(0, 1));
            datamap[i] = 8'($urandom_range(0, 255));
        end
        tick();
        tick();
        reset = 1'b0;

        chk("reset done", {done1, done0}, 2'b00);
        chk("reset rdata", {rdata1, rdata0}, 16'h0000);
        chk("reset hit", {hit1, hit0}, 2'b00);
        chk("reset busy", busy, 1'b0);
        chk("reset mem bus", {mem_rwb, mem_addr, mem_data}, 15'd0);
        chk("reset counters", {hit_cnt, miss_cnt}, 32'd0);

        for (int i = 0; i < 5; i++) run_one(vt[i], $sformatf("vec%0d", i));

        chk("rdata1 kept", rdata1, 8'h3C);
        chk("hit1 kept", hit1, 1'b1);
`ifdef MEM_ARB_STATS_EN
        chk("hit_cnt", hit_cnt, 16'd3);
        chk("miss_cnt", miss_cnt, 16'd2);
`else
        chk("hit_cnt", hit_cnt, 16'd0);
        chk("miss_cnt", miss_cnt, 16'd0);
`endif

        // Both requesters held high: grants alternate starting with port 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        use_map = 1'b0; d_hit = 1'b1; d_out = 8'h11;
        drive_port(1'b0, 1'b1, 1'b0, 6'h01, 8'h00);
        drive_port(1'b1, 1'b1, 1'b0, 6'h02, 8'h00);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k % 3 == 2) expd = (((k - 2) / 3) % 2 == 1) ? 2'b10 : 2'b01;
            else expd = 2'b00;
            chk($sformatf("rr done k=%0d", k), {done1, done0}, expd);
        end
        drive_port(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        drive_port(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
        tick();

        // Reset in the middle of a miss wait.
        d_hit = 1'b0; d_out = 8'h42;
        drive_port(1'b0, 1'b1, 1'b0, 6'h07, 8'h00);
        tick();
        tick();
        chk("mid-wait busy", busy, 1'b1);
        reset = 1'b1;
        drive_port(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        tick();
        reset = 1'b0;
        chk("abort busy", busy, 1'b0);
        chk("abort done", {done1, done0}, 2'b00);
        chk("abort mem_rwb", mem_rwb, 1'b0);
        chk("abort rdata0", rdata0, 8'h00);
        tick();
        chk("abort no late done", {done1, done0}, 2'b00);
        vf = '{1'b0, 1'b0, 6'h07, 8'h00, 1'b1, 8'h42, 8'h42, 1'b1, 2};
        run_one(vf, "after abort");

        // Randomized traffic against a transaction-level model.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        use_map = 1'b1;
        mlast = 1'b1;
        next_free = cyc;
        pend_valid = 1'b0; pend_port = 1'b0; pend_hit = 1'b0; pend_rdata = 8'h00;
        pend_cycle = 0; mhits = 0; mmiss = 0;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; rw[p] = 1'b0; ad[p] = 6'd0; wd[p] = 8'd0;
        end
        for (int it = 0; it < 600; it++) begin
            expd = (pend_valid && pend_cycle == cyc) ? (pend_port ? 2'b10 : 2'b01) : 2'b00;
            chk($sformatf("rnd done cyc=%0d", cyc), {done1, done0}, expd);
            dropped[0] = 1'b0;
            dropped[1] = 1'b0;
            if (expd != 2'b00) begin
                chk("rnd rdata", pend_port ? rdata1 : rdata0, pend_rdata);
                chk("rnd hit", pend_port ? hit1 : hit0, pend_hit);
                pend_valid = 1'b0;
                rq[pend_port] = 1'b0;
                dropped[pend_port] = 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                if (!rq[p] && !dropped[p] && it < 520 && $urandom_range(0, 2) == 0) begin
                    rq[p] = 1'b1;
                    rw[p] = 1'($urandom_range(0, 1));
                    ad[p] = 6'($urandom_range(0, 63));
                    wd[p] = 8'($urandom_range(0, 255));
                end
            end
            if (!pend_valid && cyc >= next_free && (rq[0] || rq[1])) begin
                win = (rq[0] && rq[1]) ? ~mlast : rq[1];
                mlast = win;
                pend_valid = 1'b1;
                pend_port = win;
                pend_hit = hitmap[ad[win]];
                pend_rdata = rw[win] ? 8'h00 : datamap[ad[win]];
                pend_cycle = cyc + 2 + (pend_hit ? 0 : MW);
                next_free = pend_cycle + 1;
                if (pend_hit) mhits++;
                else mmiss++;
            end
            drive_port(1'b0, rq[0], rw[0], ad[0], wd[0]);
            drive_port(1'b1, rq[1], rw[1], ad[1], wd[1]);
            tick();
        end
        chk("rnd drained", {rq[0], rq[1], pend_valid}, 3'b000);
`ifdef MEM_ARB_STATS_EN
        chk("rnd hit_cnt", hit_cnt, 16'(mhits));
        chk("rnd miss_cnt", miss_cnt, 16'(mmiss));
`else
        chk("rnd hit_cnt", hit_cnt, 16'd0);
        chk("rnd miss_cnt", miss_cnt, 16'd0);
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
